// File: rtl/apb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_pkg : shared APB state types and constants for master and slave
// Rev 1.0
// ----------------------------------------------------------------------------
package apb_pkg;

  // Master transfer phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mstate_e;

  // Existing slave's state type
  typedef enum logic [1:0] {
    SLV_IDLE = 2'd0,
    SLV_WAIT = 2'd1,
    SLV_DONE = 2'd2
  } apb_sstate_e;

  localparam int unsigned c_WAIT_W = 8;

endpackage
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master : single-outstanding APB master with valid/ready command and
//              response ports and a bounded pready wait
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

  apb_mstate_e         r_state;
  logic [c_WAIT_W-1:0] r_wait;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            // The APB address/control registers double as the command latch
            r_state   <= SETUP;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            penable   <= 1'b0;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          penable <= 1'b1;
          r_wait  <= '0;
        end
        ACCESS: begin
          // pready wins over an expiring wait count
          if (pready) begin
            r_state     <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (r_wait == c_WAIT_LAST) begin
            r_state     <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_master : directed bench for apb_master against a 32-word memory slave
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_apb_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              pclk      = 1'b0;
  logic              presetn   = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Memory slave: ws wait cycles before pready, error above word 31
  logic [DATA_W-1:0] mem [32];
  int                ws      = 1;
  int                acc_cnt = 0;
  logic              in_range;

  assign in_range = (paddr < 32);
  assign pready   = psel && penable && (acc_cnt >= ws);
  assign pslverr  = pready && !in_range;
  assign prdata   = (psel && in_range) ? mem[paddr[4:0]] : '0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && in_range) mem[paddr[4:0]] <= pwdata;
  end

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              to;
  } rsp_t;

  rsp_t              sb[$];
  logic [DATA_W-1:0] model [32];
  int                checks   = 0;
  int                failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input int stall, input bit hold, input string tag);
    rsp_t e;
    rsp_t got;
    int   n;
    int   exp_acc;
    bit   timed;
    timed   = (ws >= TIMEOUT);
    exp_acc = timed ? TIMEOUT : ws + 1;
    e.to    = timed;
    e.err   = timed || (a >= 32);
    e.rdata = (!timed && !wr && a < 32) ? model[a[4:0]] : '0;
    if (!timed && wr && a < 32) model[a[4:0]] = d;
    sb.push_back(e);

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    chk({tag, " idle bus before"}, {psel, penable}, 0);
    @(negedge pclk);
    if (!hold) cmd_valid = 1'b0;
    chk({tag, " setup"}, {psel, penable, pwrite, paddr, pwdata},
        {1'b1, 1'b0, wr, a, d});
    @(negedge pclk);
    n = 0;
    while (psel && penable && n < 300) begin
      n++;
      @(negedge pclk);
    end
    chk({tag, " access cycles"}, n, exp_acc);
    chk({tag, " bus released"}, {psel, penable}, 0);
    for (int k = 0; k < stall; k++) begin
      chk({tag, " stall hold"}, {rsp_valid, cmd_ready, rsp_rdata}, {1'b1, 1'b0, e.rdata});
      @(negedge pclk);
    end
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    got = {rsp_rdata, rsp_err, rsp_timeout};
    e   = sb.pop_front();
    chk({tag, " response"}, got, e);
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk({tag, " cmd_ready after rsp"}, {cmd_ready, rsp_valid}, 2'b10);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ctl"}, {cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}, 0);
    chk({tag, " data"}, {rsp_rdata, paddr, pwdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end

    // Power-on reset and release
    repeat (2) @(negedge pclk);
    check_reset_state("por");
    presetn = 1'b1;
    chk("por cmd_ready before edge", cmd_ready, 0);
    @(negedge pclk);
    chk("por cmd_ready after edge", cmd_ready, 1);

    // Write then read back, slave out-of-range errors
    ws = 1;
    txn(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, "wr5");
    txn(1'b0, 32'd5, 32'h0, 0, 1'b0, "rd5");
    chk("rd5 literal", model[5], 32'hDEADBEEF);
    txn(1'b0, 32'd40, 32'h0, 0, 1'b0, "rd40");
    txn(1'b1, 32'd40, 32'h12345678, 0, 1'b0, "wr40");

    // pready never arrives: timeout after TIMEOUT access cycles
    ws = 1000;
    txn(1'b0, 32'd7, 32'h0, 0, 1'b0, "timeout");

    // pready on the last permitted cycle completes normally
    ws = TIMEOUT - 1;
    txn(1'b0, 32'd5, 32'h0, 0, 1'b0, "late pready");

    // Zero-wait slave and a stalled response consumer
    ws = 0;
    txn(1'b1, 32'd9, 32'hCAFEF00D, 0, 1'b0, "wr9 nowait");
    ws = 1;
    txn(1'b0, 32'd9, 32'h0, 5, 1'b0, "rsp stall");

    // Reset pulsed while in ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd5;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("midrst in access", {psel, penable}, 2'b11);
    presetn = 1'b0;
    #1;
    chk("midrst bus drop", {psel, penable}, 0);
    check_reset_state("midrst");
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk);
      chk("midrst no rsp", rsp_valid, 0);
    end
    presetn = 1'b1;
    chk("midrst cmd_ready before edge", cmd_ready, 0);
    @(negedge pclk);
    chk("midrst cmd_ready after edge", {cmd_ready, rsp_valid}, 2'b10);

    // Back-to-back writes with cmd_valid held high
    for (int i = 0; i < 32; i++) txn(1'b1, i, 32'hA5000000 + i, 0, 1'b1, "b2b wr");
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("b2b no extra txn", {psel, rsp_valid}, 0);
    ws = 0;
    txn(1'b0, 32'd0, 32'h0, 0, 1'b0, "b2b rd0");
    txn(1'b0, 32'd31, 32'h0, 0, 1'b0, "b2b rd31");
    chk("scoreboard empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
